// File: rtl/swap_sched.sv
// swap_sched: round-robin front end for the two-port byte swap engine.
// Accepts one request per idle cycle, paces engine commands to its 3-cycle operation.
module swap_sched #(
    parameter int AW        = 32,
    parameter bit SKIP_SAME = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [AW-1:0]    req0_addra,
    input  logic [AW-1:0]    req0_addrb,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [AW-1:0]    req1_addra,
    input  logic [AW-1:0]    req1_addrb,
    output logic             sw_start,
    output logic [AW-1:0]    sw_addra,
    output logic [AW-1:0]    sw_addrb,
    output logic             done_valid,
    output logic             done_id,
    output logic             busy,
    output logic [CNT_W-1:0] swap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RD    = 2'd2,
        S_WR    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rr_ptr;
    logic            cur_id;
    logic            grant_any;
    logic            grant_id;
    logic [AW-1:0]   sel_a;
    logic [AW-1:0]   sel_b;
    logic            skip;

    // Grant only while idle; a contested cycle goes to the side rr_ptr points at.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = rr_ptr;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any && grant_id;
    assign sel_a      = grant_id ? req1_addra : req0_addra;
    assign sel_b      = grant_id ? req1_addrb : req0_addrb;
    assign skip       = SKIP_SAME && (sel_a == sel_b);
    assign busy       = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_any && !skip) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_RD;
            S_RD:    state_nxt = S_WR;
            S_WR:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Operands are latched on every accept, skipped ones included, and held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_start   <= 1'b0;
            sw_addra   <= '0;
            sw_addrb   <= '0;
            done_valid <= 1'b0;
            done_id    <= 1'b0;
            cur_id     <= 1'b0;
            rr_ptr     <= 1'b0;
            swap_cnt   <= '0;
        end else begin
            sw_start   <= (state_nxt == S_ISSUE);
            done_valid <= 1'b0;
            if (grant_any) begin
                sw_addra <= sel_a;
                sw_addrb <= sel_b;
                cur_id   <= grant_id;
                rr_ptr   <= ~grant_id;
            end
            if (grant_any && skip) begin
                done_valid <= 1'b1;
                done_id    <= grant_id;
                swap_cnt   <= swap_cnt + CNT_W'(1);
            end else if (state == S_WR) begin
                done_valid <= 1'b1;
                done_id    <= cur_id;
                swap_cnt   <= swap_cnt + CNT_W'(1);
            end
        end
    end

    a_one_ready: assert property (@(posedge clk) disable iff (!rst)
        !(req0_ready && req1_ready));

    // The engine reuses the operands as write addresses, so they must not move mid-swap.
    a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        (state != S_IDLE) |=> ($stable(sw_addra) && $stable(sw_addrb)));

endmodule

// File: tb/tb_swap_sched.sv
// tb_swap_sched: randomized and directed checks of swap_sched against a cycle-time reference model.
// A second instance (no skip, 4-bit counter) covers the parameter-dependent behaviour.
module tb_swap_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        r0v = 1'b0;
    logic        r1v = 1'b0;
    logic [31:0] r0a = '0;
    logic [31:0] r0b = '0;
    logic [31:0] r1a = '0;
    logic [31:0] r1b = '0;

    logic        r0rdy, r1rdy, sw_start, done_valid, done_id, busy;
    logic [31:0] sw_addra, sw_addrb;
    logic [15:0] swap_cnt;

    logic        d2_r0rdy, d2_r1rdy, d2_start, d2_done, d2_done_id, d2_busy;
    logic [31:0] d2_a, d2_b;
    logic [3:0]  d2_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    swap_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0rdy), .req0_addra(r0a), .req0_addrb(r0b),
        .req1_valid(r1v), .req1_ready(r1rdy), .req1_addra(r1a), .req1_addrb(r1b),
        .sw_start(sw_start), .sw_addra(sw_addra), .sw_addrb(sw_addrb),
        .done_valid(done_valid), .done_id(done_id), .busy(busy), .swap_cnt(swap_cnt)
    );

    swap_sched #(.AW(32), .SKIP_SAME(1'b0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(d2_r0rdy), .req0_addra(r0a), .req0_addrb(r0b),
        .req1_valid(r1v), .req1_ready(d2_r1rdy), .req1_addra(r1a), .req1_addrb(r1b),
        .sw_start(d2_start), .sw_addra(d2_a), .sw_addrb(d2_b),
        .done_valid(d2_done), .done_id(d2_done_id), .busy(d2_busy), .swap_cnt(d2_cnt)
    );

    wire  [85:0] obs_vec = {r0rdy, r1rdy, sw_start, busy, done_valid, done_valid & done_id,
                            sw_addra, sw_addrb, swap_cnt};
    logic [85:0] exp_vec;

    // Behavioural engine: samples start, reads the next cycle, writes back swapped the cycle after.
    logic [7:0] eng_a [256];
    logic [7:0] eng_b [256];
    logic [7:0] exp_a [256];
    logic [7:0] exp_b [256];
    logic [7:0] eng_ra, eng_rb;
    int         eng_ph;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_ph = 0;
        end else begin
            case (eng_ph)
                0: if (sw_start) eng_ph = 1;
                1: begin
                    eng_ra = eng_a[sw_addra[7:0]];
                    eng_rb = eng_b[sw_addrb[7:0]];
                    eng_ph = 2;
                end
                default: begin
                    eng_a[sw_addra[7:0]] = eng_rb;
                    eng_b[sw_addrb[7:0]] = eng_ra;
                    eng_ph = 0;
                end
            endcase
        end
    end

    // Reference model: accepts are scheduled as future events in absolute cycle numbers.
    typedef struct {
        int         cyc;
        bit         id;
        bit         skip;
        logic [7:0] ia;
        logic [7:0] ib;
    } done_t;

    done_t       done_q[$];
    int          start_q[$];
    int          now;
    int          busy_end;
    bit          rr;
    bit          acc0, acc1;
    logic [31:0] ma, mb;
    logic [15:0] cnt;

    function automatic void model_reset();
        now      = 0;
        busy_end = 0;
        rr       = 1'b0;
        acc0     = 1'b0;
        acc1     = 1'b0;
        ma       = '0;
        mb       = '0;
        cnt      = '0;
        done_q.delete();
        start_q.delete();
    endfunction

    function automatic void model_cycle();
        bit          e_start = 1'b0;
        bit          e_done  = 1'b0;
        bit          e_id    = 1'b0;
        bit          g       = 1'b0;
        logic [31:0] a, b;
        logic [7:0]  tmp;
        done_t       d;
        if (start_q.size() > 0 && start_q[0] == now) begin
            e_start = 1'b1;
            void'(start_q.pop_front());
        end
        if (done_q.size() > 0 && done_q[0].cyc == now) begin
            d      = done_q.pop_front();
            e_done = 1'b1;
            e_id   = d.id;
            cnt    = cnt + 16'd1;
            if (!d.skip) begin
                tmp         = exp_a[d.ia];
                exp_a[d.ia] = exp_b[d.ib];
                exp_b[d.ib] = tmp;
            end
        end
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (now >= busy_end && (r0v || r1v)) begin
            g    = (r0v && r1v) ? rr : r1v;
            acc0 = !g;
            acc1 = g;
        end
        exp_vec = {acc0, acc1, e_start, (now < busy_end), e_done, e_done & e_id, ma, mb, cnt};
        if (acc0 || acc1) begin
            a  = g ? r1a : r0a;
            b  = g ? r1b : r0b;
            ma = a;
            mb = b;
            rr = !g;
            if (a == b) begin
                done_q.push_back('{cyc: now + 1, id: g, skip: 1'b1, ia: a[7:0], ib: b[7:0]});
            end else begin
                start_q.push_back(now + 1);
                done_q.push_back('{cyc: now + 4, id: g, skip: 1'b0, ia: a[7:0], ib: b[7:0]});
                busy_end = now + 4;
            end
        end
        now++;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (obs_vec !== '0 || {d2_r0rdy, d2_r1rdy, d2_start, d2_done, d2_done_id, d2_busy,
                                d2_a, d2_b, d2_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got=%h exp=0", obs_vec);
        end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        r0v = 1'b1; r0a = 32'h30; r0b = 32'h40;
        for (int k = 0; k < 2; k++) begin
            #1;
            model_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL abort_issue cyc=%0d got=%h exp=%h", now - 1, obs_vec, exp_vec);
            end
            @(negedge clk);
            if (acc0) r0v = 1'b0;
        end
        #2 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (obs_vec !== '0) begin
                errors++;
                $display("[TB] FAIL abort_reset step=%0d got=%h exp=0", k, obs_vec);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        model_reset();
        r0v = 1'b1; r0a = 32'h31; r0b = 32'h41;
        r1v = 1'b1; r1a = 32'h32; r1b = 32'h42;
        #1;
        checks++;
        if ({r0rdy, r1rdy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL first_grant got=%b exp=10", {r0rdy, r1rdy});
        end
        for (int k = 0; k < 12; k++) begin
            if (k > 0) #1;
            model_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL post_reset cyc=%0d got=%h exp=%h", now - 1, obs_vec, exp_vec);
            end
            @(negedge clk);
            if (acc0) r0v = 1'b0;
            if (acc1) r1v = 1'b0;
        end
    endtask

    task automatic test_single();
        int t0 = -1;
        r0v = 1'b1; r0a = 32'h10; r0b = 32'h20;
        for (int k = 0; k < 7; k++) begin
            #1;
            model_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL single cyc=%0d got=%h exp=%h", now - 1, obs_vec, exp_vec);
            end
            if (acc0) t0 = k;
            @(negedge clk);
            if (acc0) r0v = 1'b0;
        end
        checks++;
        if (t0 != 0 || eng_a[8'h10] !== 8'h85 || eng_b[8'h20] !== 8'h10) begin
            errors++;
            $display("[TB] FAIL single_mem got a=%h b=%h exp a=85 b=10", eng_a[8'h10], eng_b[8'h20]);
        end
    endtask

    task automatic test_alternate();
        bit grants[$];
        bit alt_ok = 1'b1;
        r0v = 1'b1; r0a = $urandom; r0b = r0a + 32'd1;
        r1v = 1'b1; r1a = $urandom; r1b = r1a + 32'd1;
        for (int k = 0; k < 28; k++) begin
            #1;
            model_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL alternate cyc=%0d got=%h exp=%h", now - 1, obs_vec, exp_vec);
            end
            if (r0rdy) grants.push_back(1'b0);
            if (r1rdy) grants.push_back(1'b1);
            @(negedge clk);
            if (k >= 23) begin
                r0v = 1'b0;
                r1v = 1'b0;
            end
            if (acc0) begin r0a = $urandom; r0b = r0a + 32'd1; end
            if (acc1) begin r1a = $urandom; r1b = r1a + 32'd1; end
        end
        for (int i = 1; i < grants.size(); i++)
            if (grants[i] == grants[i-1]) alt_ok = 1'b0;
        checks++;
        if (grants.size() != 6 || !alt_ok) begin
            errors++;
            $display("[TB] FAIL alternate_order got grants=%0d alt=%0d exp grants=6 alt=1",
                     grants.size(), alt_ok);
        end
    endtask

    task automatic test_skip();
        r1v = 1'b1; r1a = 32'h55; r1b = 32'h55;
        for (int k = 0; k < 6; k++) begin
            #1;
            model_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL skip cyc=%0d got=%h exp=%h", now - 1, obs_vec, exp_vec);
            end
            checks++;
            if ({d2_start, d2_done, d2_done & d2_done_id} !== {k == 1, k == 4, k == 4}) begin
                errors++;
                $display("[TB] FAIL noskip k=%0d got=%b exp=%b", k,
                         {d2_start, d2_done, d2_done_id}, {k == 1, k == 4, k == 4});
            end
            @(negedge clk);
            if (acc1) r1v = 1'b0;
        end
        r0v = 1'b1; r0a = $urandom; r0b = r0a;
        r1v = 1'b1; r1a = $urandom; r1b = r1a;
        for (int k = 0; k < 12; k++) begin
            #1;
            model_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL skip_burst cyc=%0d got=%h exp=%h", now - 1, obs_vec, exp_vec);
            end
            @(negedge clk);
            if (k >= 8) begin
                r0v = 1'b0;
                r1v = 1'b0;
            end
            if (acc0) begin r0a = $urandom; r0b = r0a; end
            if (acc1) begin r1a = $urandom; r1b = r1a; end
        end
    endtask

    task automatic test_wrap();
        int nacc  = 0;
        int ndone = 0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        r0v = 1'b1; r0a = $urandom; r0b = r0a ^ 32'h0000_0100;
        for (int k = 0; k < 68; k++) begin
            #1;
            model_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL wrap cyc=%0d got=%h exp=%h", now - 1, obs_vec, exp_vec);
            end
            if (d2_done) begin
                ndone++;
                checks++;
                if (d2_cnt !== 4'(ndone)) begin
                    errors++;
                    $display("[TB] FAIL wrap_cnt4 done=%0d got=%0d exp=%0d", ndone, d2_cnt, 4'(ndone));
                end
            end
            @(negedge clk);
            if (acc0) begin
                nacc++;
                r0a = $urandom;
                r0b = r0a ^ 32'h0000_0100;
                if (nacc == 16) r0v = 1'b0;
            end
        end
        checks++;
        if (ndone != 16 || d2_cnt !== 4'd0 || swap_cnt !== 16'd16) begin
            errors++;
            $display("[TB] FAIL wrap_final got done=%0d cnt4=%0d cnt16=%0d exp 16/0/16",
                     ndone, d2_cnt, swap_cnt);
        end
    endtask

    task automatic test_during_rd();
        int t1 = -1;
        r0v = 1'b1; r0a = 32'h0A; r0b = 32'h0B;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) begin
                r1v = 1'b1; r1a = 32'h1A; r1b = 32'h1B;
            end
            #1;
            model_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL during_rd cyc=%0d got=%h exp=%h", now - 1, obs_vec, exp_vec);
            end
            if (r1rdy) t1 = k;
            @(negedge clk);
            if (acc0) r0v = 1'b0;
            if (acc1) r1v = 1'b0;
        end
        checks++;
        if (t1 != 4) begin
            errors++;
            $display("[TB] FAIL during_rd_accept got=%0d exp=4", t1);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 406; k++) begin
            if (k < 400) begin
                if (!r0v && $urandom_range(0, 1) == 1) begin
                    r0v = 1'b1;
                    r0a = $urandom;
                    r0b = ($urandom_range(0, 3) == 0) ? r0a : $urandom;
                end
                if (!r1v && $urandom_range(0, 1) == 1) begin
                    r1v = 1'b1;
                    r1a = $urandom;
                    r1b = ($urandom_range(0, 3) == 0) ? r1a : $urandom;
                end
            end
            #1;
            model_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d got=%h exp=%h", now - 1, obs_vec, exp_vec);
            end
            @(negedge clk);
            if (acc0 || k >= 399) r0v = 1'b0;
            if (acc1 || k >= 399) r1v = 1'b0;
        end
        for (int i = 0; i < 256; i++)
            if (eng_a[i] !== exp_a[i] || eng_b[i] !== exp_b[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL random_mem got=%0d differing entries exp=0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            eng_a[i] = 8'(i);
            eng_b[i] = 8'(i) ^ 8'hA5;
            exp_a[i] = 8'(i);
            exp_b[i] = 8'(i) ^ 8'hA5;
        end
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_alternate();
        test_skip();
        test_wrap();
        test_during_rd();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
